// File: rtl/hit_pixel_writer.sv
// Raster-order framebuffer writer: turns per-pixel intersection results into RGB444 BRAM writes.
// Optional distance shading of hits is enabled by defining HIT_PIXEL_WRITER_DEPTH_SHADE_EN.
module hit_pixel_writer #(
  parameter int          H_RES      = 1024,
  parameter int          V_RES      = 768,
  parameter int          NUM_BLOCKS = 4,
  parameter logic [11:0] BG_COLOR   = 12'h000,
  parameter logic [11:0] EVEN_COLOR = 12'hF00,
  parameter logic [11:0] ODD_COLOR  = 12'h00F
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        frame_start_in,
  input  logic        valid_in,
  input  logic [11:0] best_block_in,
  input  logic [31:0] best_t_in,
  output logic        wr_en_out,
  output logic [19:0] wr_addr_out,
  output logic [11:0] wr_data_out,
  output logic [10:0] x_out,
  output logic [9:0]  y_out,
  output logic        busy_out,
  output logic        frame_done_out,
  output logic [15:0] drop_count_out
);

  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

  localparam logic [10:0] X_LAST = 11'(H_RES - 1);
  localparam logic [9:0]  Y_LAST = 10'(V_RES - 1);

  function automatic logic is_miss(input logic [11:0] blk, input logic sign);
    return (blk >= 12'(NUM_BLOCKS)) || sign;
  endfunction

  function automatic logic [11:0] palette(input logic blk_lsb);
    return blk_lsb ? ODD_COLOR : EVEN_COLOR;
  endfunction

`ifdef HIT_PIXEL_WRITER_DEPTH_SHADE_EN
  // Exponent above the bias means t >= 2.0; each octave dims one more step, up to 3.
  function automatic logic [1:0] shade_shift(input logic [7:0] e);
    if (e <= 8'd127)
      return 2'd0;
    else if (e >= 8'd130)
      return 2'd3;
    else
      return 2'(e - 8'd127);
  endfunction

  function automatic logic [11:0] shade(input logic [11:0] c, input logic [1:0] s);
    return {c[11:8] >> s, c[7:4] >> s, c[3:0] >> s};
  endfunction
`endif

  state_t      state, state_nxt;
  logic [10:0] x_cnt, x_nxt, x_cur;
  logic [9:0]  y_cnt, y_nxt, y_cur;
  logic [19:0] addr_cnt, addr_nxt, addr_cur;
  logic        accept, pix_last, drop, frame_done_nxt;

  logic        vld_p0, last_p0, miss_p0;
  logic [10:0] x_p0;
  logic [9:0]  y_p0;
  logic [19:0] addr_p0;
  logic [11:0] color_p0;
  logic        last_p1;

`ifdef HIT_PIXEL_WRITER_DEPTH_SHADE_EN
  logic [1:0]  shift_p0;
  logic        unused_t;
  assign unused_t = ^best_t_in[22:0];
`else
  logic        unused_t;
  assign unused_t = ^best_t_in[30:0];
`endif

  // A frame start restarts numbering so a coincident valid becomes pixel (0,0).
  always_comb begin
    x_cur    = frame_start_in ? 11'd0 : x_cnt;
    y_cur    = frame_start_in ? 10'd0 : y_cnt;
    addr_cur = frame_start_in ? 20'd0 : addr_cnt;
    accept   = valid_in && (frame_start_in || (state == ACTIVE));
    drop     = valid_in && !accept;
    pix_last = (x_cur == X_LAST) && (y_cur == Y_LAST);
  end

  always_comb begin
    state_nxt      = state;
    x_nxt          = x_cur;
    y_nxt          = y_cur;
    addr_nxt       = addr_cur;
    frame_done_nxt = 1'b0;
    if (frame_start_in) begin
      state_nxt = ACTIVE;
    end else if ((state == DONE) && last_p1) begin
      state_nxt      = IDLE;
      frame_done_nxt = 1'b1;
    end
    if (accept) begin
      if (x_cur == X_LAST) begin
        x_nxt = 11'd0;
        y_nxt = (y_cur == Y_LAST) ? 10'd0 : y_cur + 10'd1;
      end else begin
        x_nxt = x_cur + 11'd1;
      end
      addr_nxt = pix_last ? 20'd0 : addr_cur + 20'd1;
      if (pix_last)
        state_nxt = DONE;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state          <= IDLE;
      x_cnt          <= '0;
      y_cnt          <= '0;
      addr_cnt       <= '0;
      drop_count_out <= '0;
      frame_done_out <= 1'b0;
      vld_p0         <= 1'b0;
      last_p0        <= 1'b0;
      wr_en_out      <= 1'b0;
      last_p1        <= 1'b0;
    end else begin
      state          <= state_nxt;
      x_cnt          <= x_nxt;
      y_cnt          <= y_nxt;
      addr_cnt       <= addr_nxt;
      frame_done_out <= frame_done_nxt;
      if (drop && (drop_count_out != 16'hFFFF))
        drop_count_out <= drop_count_out + 16'd1;
      vld_p0         <= accept;
      last_p0        <= accept && pix_last;
      wr_en_out      <= vld_p0;
      last_p1        <= vld_p0 && last_p0;
    end
  end

  // Stage 1: tag with coordinates and classify hit/miss.
  always_ff @(posedge clk_in) begin
    if (accept) begin
      x_p0     <= x_cur;
      y_p0     <= y_cur;
      addr_p0  <= addr_cur;
      miss_p0  <= is_miss(best_block_in, best_t_in[31]);
      color_p0 <= palette(best_block_in[0]);
`ifdef HIT_PIXEL_WRITER_DEPTH_SHADE_EN
      shift_p0 <= shade_shift(best_t_in[30:23]);
`endif
    end
  end

  // Stage 2: final colour onto the write port; fields hold between writes.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      wr_addr_out <= '0;
      wr_data_out <= '0;
      x_out       <= '0;
      y_out       <= '0;
    end else if (vld_p0) begin
      wr_addr_out <= addr_p0;
      x_out       <= x_p0;
      y_out       <= y_p0;
`ifdef HIT_PIXEL_WRITER_DEPTH_SHADE_EN
      wr_data_out <= miss_p0 ? BG_COLOR : shade(color_p0, shift_p0);
`else
      wr_data_out <= miss_p0 ? BG_COLOR : color_p0;
`endif
    end
  end

  assign busy_out = (state == ACTIVE);

endmodule

// File: tb/tb_hit_pixel_writer.sv
// Scoreboard bench for hit_pixel_writer on an 8x2 frame; expectations follow the shade macro if defined.
module tb_hit_pixel_writer;

  localparam logic [31:0] T_1P0  = 32'h3F800000;
  localparam logic [31:0] T_4P0  = 32'h40800000;
  localparam logic [31:0] T_1E6  = 32'h49742400;
  localparam logic [31:0] T_M2P0 = 32'hC0000000;

  logic        clk = 1'b0;
  logic        rst_in = 1'b1;
  logic        frame_start_in = 1'b0;
  logic        valid_in = 1'b0;
  logic [11:0] best_block_in = '0;
  logic [31:0] best_t_in = '0;
  logic        wr_en_out;
  logic [19:0] wr_addr_out;
  logic [11:0] wr_data_out;
  logic [10:0] x_out;
  logic [9:0]  y_out;
  logic        busy_out;
  logic        frame_done_out;
  logic [15:0] drop_count_out;

  always #5 clk = ~clk;

  hit_pixel_writer #(.H_RES(8), .V_RES(2)) dut (
    .clk_in(clk), .rst_in(rst_in), .frame_start_in(frame_start_in), .valid_in(valid_in),
    .best_block_in(best_block_in), .best_t_in(best_t_in), .wr_en_out(wr_en_out),
    .wr_addr_out(wr_addr_out), .wr_data_out(wr_data_out), .x_out(x_out), .y_out(y_out),
    .busy_out(busy_out), .frame_done_out(frame_done_out), .drop_count_out(drop_count_out)
  );

  typedef struct {
    logic [19:0] addr;
    logic [11:0] data;
    logic [10:0] x;
    logic [9:0]  y;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int cyc = 0;
  int errors = 0, checks = 0;
  int mon_errors = 0, mon_checks = 0;
  int done_cnt = 0;
  logic [19:0] done_prev_addr = 20'hFFFFF;
  logic        prev_wr = 1'b0;
  logic [19:0] prev_addr = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wr_en_out) begin
      mon_checks++;
      if (sb.size() == 0) begin
        mon_errors++;
        $display("FAIL unexpected_write: got addr=%0d data=%h, required no write", wr_addr_out, wr_data_out);
      end else begin
        e = sb.pop_front();
        if (wr_addr_out !== e.addr || wr_data_out !== e.data || x_out !== e.x ||
            y_out !== e.y || cyc !== e.cyc) begin
          mon_errors++;
          $display("FAIL write: got addr=%0d data=%h x=%0d y=%0d cyc=%0d, required addr=%0d data=%h x=%0d y=%0d cyc=%0d",
                   wr_addr_out, wr_data_out, x_out, y_out, cyc, e.addr, e.data, e.x, e.y, e.cyc);
        end
      end
    end
    if (frame_done_out) begin
      done_cnt++;
      done_prev_addr = prev_wr ? prev_addr : 20'hFFFFF;
    end
    prev_wr   = wr_en_out;
    prev_addr = wr_addr_out;
  end

  function automatic logic [11:0] exp_color(input logic [11:0] blk, input logic [31:0] t);
    logic [11:0] c;
    int sh;
    if (blk >= 12'd4 || t[31]) return 12'h000;
    c = blk[0] ? 12'h00F : 12'hF00;
`ifdef HIT_PIXEL_WRITER_DEPTH_SHADE_EN
    sh = (int'(t[30:23]) <= 127) ? 0 : ((int'(t[30:23]) - 127 > 3) ? 3 : int'(t[30:23]) - 127);
    c = {c[11:8] >> sh, c[7:4] >> sh, c[3:0] >> sh};
`else
    sh = 0;
`endif
    return c;
  endfunction

  task automatic drive(input logic start, input logic vld, input logic [11:0] blk, input logic [31:0] t);
    @(negedge clk);
    frame_start_in = start;
    valid_in       = vld;
    best_block_in  = blk;
    best_t_in      = t;
  endtask

  task automatic push(input int addr, input logic [11:0] data, input int x, input int y);
    exp_t n;
    n.addr = 20'(addr); n.data = data; n.x = 11'(x); n.y = 10'(y); n.cyc = cyc + 2;
    sb.push_back(n);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 12'd0, 32'd0);
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 20 && sb.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: got %0d writes outstanding, required 0", name, sb.size());
    end
  endtask

  task automatic test_reset();
    rst_in = 1'b0;
    @(negedge clk);
    checks++;
    if ({wr_en_out, wr_addr_out, wr_data_out, x_out, y_out} !== '0) begin
      errors++;
      $display("FAIL reset_write_port: got en=%b addr=%0d data=%h x=%0d y=%0d, required all 0",
               wr_en_out, wr_addr_out, wr_data_out, x_out, y_out);
    end
    checks++;
    if ({busy_out, frame_done_out, drop_count_out} !== '0) begin
      errors++;
      $display("FAIL reset_status: got busy=%b done=%b drop=%0d, required 0", busy_out, frame_done_out, drop_count_out);
    end
    rst_in = 1'b1;
    idle(2);
    checks++;
    if (busy_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle_busy: got %b, required 0", busy_out);
    end
  endtask

  task automatic test_drop();
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 12'(i), T_1P0);
    idle(1);
    checks++;
    if (drop_count_out !== 16'd3) begin
      errors++;
      $display("FAIL drop_idle: got %0d, required 3", drop_count_out);
    end
    drive(1'b1, 1'b1, 12'd1, T_1P0);
    push(0, 12'h00F, 0, 0);
    idle(1);
    checks++;
    if (drop_count_out !== 16'd3) begin
      errors++;
      $display("FAIL drop_start_valid: got %0d, required 3", drop_count_out);
    end
    wait_drain("drop");
  endtask

  task automatic test_basic();
    int d0;
    logic [11:0] blks [4];
    logic [11:0] cols [4];
    blks = '{12'd0, 12'd1, 12'd256, 12'd2};
    cols = '{12'hF00, 12'h00F, 12'h000, 12'hF00};
    @(negedge clk); rst_in = 1'b0;
    @(negedge clk); rst_in = 1'b1;
    d0 = done_cnt;
    drive(1'b1, 1'b0, 12'd0, 32'd0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, blks[i], T_1P0);
      push(i, cols[i], i, 0);
      if (i == 0) begin
        checks++;
        if (busy_out !== 1'b1) begin
          errors++;
          $display("FAIL basic_busy_rise: got %b, required 1", busy_out);
        end
      end
    end
    idle(1);
    wait_drain("basic");
    checks++;
    if (busy_out !== 1'b1 || done_cnt !== d0) begin
      errors++;
      $display("FAIL basic_partial_frame: got busy=%b dones=%0d, required busy=1 dones=0", busy_out, done_cnt - d0);
    end
  endtask

  task automatic test_restart_full();
    int d0, drops;
    logic [11:0] blk;
    logic [31:0] t;
    d0 = done_cnt;
    drive(1'b1, 1'b0, 12'd0, 32'd0);
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b1, 12'(i), T_1P0);
      push(i, exp_color(12'(i), T_1P0), i, 0);
    end
    drive(1'b1, 1'b0, 12'd0, 32'd0);
    for (int i = 0; i < 16; i++) begin
      blk = 12'(i % 6);
      t   = (i == 9) ? T_M2P0 : T_1P0;
      drive(1'b0, 1'b1, blk, t);
      push(i, exp_color(blk, t), i % 8, i / 8);
    end
    drive(1'b0, 1'b0, 12'd0, 32'd0);
    checks++;
    if (busy_out !== 1'b0) begin
      errors++;
      $display("FAIL full_busy_fall: got %b, required 0", busy_out);
    end
    wait_drain("full");
    idle(2);
    checks++;
    if (done_cnt - d0 !== 1) begin
      errors++;
      $display("FAIL full_done_count: got %0d, required 1", done_cnt - d0);
    end
    checks++;
    if (done_prev_addr !== 20'd15) begin
      errors++;
      $display("FAIL full_done_timing: got write addr before done=%0d, required 15", done_prev_addr);
    end
    drops = int'(drop_count_out);
    drive(1'b0, 1'b1, 12'd0, T_1P0);
    idle(1);
    checks++;
    if (int'(drop_count_out) !== drops + 1 || busy_out !== 1'b0) begin
      errors++;
      $display("FAIL full_back_to_idle: got drop=%0d busy=%b, required drop=%0d busy=0", drop_count_out, busy_out, drops + 1);
    end
  endtask

  task automatic test_shade();
    logic [31:0] ts [4];
    logic [11:0] cs [4];
    ts = '{T_1P0, T_4P0, T_1E6, T_M2P0};
`ifdef HIT_PIXEL_WRITER_DEPTH_SHADE_EN
    cs = '{12'hF00, 12'h300, 12'h100, 12'h000};
`else
    cs = '{12'hF00, 12'hF00, 12'hF00, 12'h000};
`endif
    drive(1'b1, 1'b0, 12'd0, 32'd0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 12'd0, ts[i]);
      push(i, cs[i], i, 0);
    end
    idle(1);
    wait_drain("shade");
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 1'b1, 12'd0, T_1P0);
    push(0, 12'hF00, 0, 0);
    drive(1'b0, 1'b1, 12'd1, T_1P0);
    push(1, 12'h00F, 1, 0);
    drive(1'b0, 1'b1, 12'd2, T_1P0);
    push(2, 12'hF00, 2, 0);
    @(negedge clk);
    #1;
    rst_in = 1'b0;
    sb.delete();
    @(negedge clk);
    checks++;
    if ({wr_en_out, wr_addr_out, wr_data_out, x_out, y_out, busy_out, frame_done_out, drop_count_out} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: got en=%b addr=%0d data=%h x=%0d y=%0d busy=%b done=%b drop=%0d, required all 0",
               wr_en_out, wr_addr_out, wr_data_out, x_out, y_out, busy_out, frame_done_out, drop_count_out);
    end
    rst_in   = 1'b1;
    valid_in = 1'b0;
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 12'd0, T_1P0);
    idle(3);
    checks++;
    if (drop_count_out !== 16'd3 || busy_out !== 1'b0) begin
      errors++;
      $display("FAIL midreset_no_writes: got drop=%0d busy=%b, required drop=3 busy=0", drop_count_out, busy_out);
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_drop();
    test_basic();
    test_restart_full();
    test_shade();
    test_reset_mid();
    idle(2);
    errors = errors + mon_errors;
    checks = checks + mon_checks;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no completion, required completion");
    $fatal(1, "timeout");
  end

endmodule
